pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined two-operand adder/subtractor for the multiplier datapath, used as the final carry-propagate stage after partial-product reduction and as a standalone wide adder. The operand is split into `WIDTH/SEG_W` segments, each resolved in its own pipeline stage with the inter-segment carry registered. It accepts one operation per cycle under a valid/ready handshake with full backpressure, and produces the sum and a true carry-out.

## Interface
- `WIDTH`, 32: operand and sum width; must be a multiple of `SEG_W`. Elaboration error otherwise.
- `SEG_W`, 8: segment width per pipeline stage. `NSEG = WIDTH/SEG_W` is the number of stages and the latency.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and mode are valid.
- `in_ready` output 1: block accepts an input this cycle.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_sub` input 1: 0 computes A+B; 1 computes A−B.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output WIDTH: result, modulo 2^WIDTH.
- `out_carry` output 1: carry-out of the MSB. For subtraction, 1 means no borrow (A ≥ B unsigned).
- `out_ovf` output 1: signed overflow. Present only with `PIPE_ADDER_OVF_EN`.

## Operation
- Input handshake fires when `in_valid && in_ready`. Output handshake fires when `out_valid && out_ready`.
- Subtraction is performed as A + ~B + 1: B is inverted and the stage-0 carry-in is set to `in_sub`.
- Stage k (k = 0..NSEG−1) adds segment k of A and B' with the carry from stage k−1.
  - The stage register holds the per-stage valid bit, the full A and B', the sum segments resolved so far, and the carry.
  - Carry width is exactly 1 bit per boundary. Sum bits above segment k are don't-care until resolved.
- Global stall: `stall = out_valid && !out_ready`. When `stall` is high, every stage register holds its contents.
- `in_ready = !stall`, purely combinational from `out_valid` and `out_ready`.
- Bubbles (stage valid = 0) propagate normally. There is no bubble collapsing, and ordering is strictly FIFO.
- `out_carry` is the stage NSEG−1 carry-out. `out_sum` is the concatenation of all resolved segments.
- Reset (asynchronous, at any time including mid-operation):
  - All stage valid bits clear, so `out_valid` = 0.
  - `out_sum`, `out_carry` and `out_ovf` = 0.
  - In-flight operations are discarded and never emitted.
- State: no FSM. Pipeline occupancy is tracked solely by the NSEG valid bits.

## Timing
- Latency: an input accepted at edge t appears with `out_valid` = 1 after edge t+NSEG−1, i.e. NSEG register stages. With the defaults that is 4 cycles.
- Throughput: one operation per cycle when `out_ready` stays high.
- `out_*` are registered and remain stable while `out_valid && !out_ready`.
- Combinational path per stage: one SEG_W-bit ripple add plus carry-in. No path crosses a stage.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- Simultaneous input accept and output accept in the same cycle is legal and the normal steady state.

## Configuration
- `PIPE_ADDER_OVF_EN` defined:
  - Adds the `out_ovf` port.
  - Overflow = carry into MSB XOR carry out of MSB, computed in the last stage and registered alongside `out_sum`. Reset value 0.
  - For subtraction it uses the inverted B.
- Not defined: the `out_ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `pipe_adder_pkg`:
  - Localparam helper function for `NSEG`.
  - Default `WIDTH` and `SEG_W` constants.
  - Typedef for the per-stage register bundle: valid, a, b, sum, carry.
- Sub-module `adder_seg`: combinational SEG_W-bit ripple adder with ports `a`, `b`, `cin`, `s`, `cout`, instantiated once per stage via generate.
- Top level contains the stage registers, the stall logic and the handshake.

## Test plan
All scenarios use defaults (WIDTH=32, SEG_W=8) unless stated.
- Carry ripple: A=0xFFFFFFFF, B=0x00000001, sub=0 → sum 0x00000000, carry 1, `out_valid` exactly 4 cycles after accept.
- Borrow: A=5, B=7, sub=1 → sum 0xFFFFFFFE, carry 0. Then A=7, B=5, sub=1 → sum 0x00000002, carry 1.
- Backpressure: stream 8 random operations back-to-back and hold `out_ready`=0 for 3 cycles mid-stream.
  - Required: `in_ready`=0 for exactly those cycles, outputs held stable, and all 8 results correct and in order against a reference model.
- Reset mid-flight: 3 operations in the pipe, pulse `rst_n` low asynchronously between edges.
  - Required: `out_valid`=0 immediately, outputs 0, and none of the 3 results ever emitted.
- Overflow (macro on):
  - 0x7FFFFFFF + 1 → ovf 1, sum 0x80000000.
  - 0x80000000 − 1 → ovf 1.
  - 0x00000003 + 0x00000004 → ovf 0.
- Reparametrisation (WIDTH=16, SEG_W=4): 0xABCD + 0x1234 → sum 0xBE01, carry 0, latency 4. WIDTH=30, SEG_W=8 must fail elaboration.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants, stage-count helper and stage control bundle for pipe_adder.
package pipe_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_SEG_W = 8;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

  // Width-independent part of each stage register; the data fields depend on WIDTH.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit ripple adder with carry in/out; one instance per pipeline stage.
module adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int unsigned SEG_W = DEFAULT_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor, one SEG_W segment resolved per stage with a global stall.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output out_ovf.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SEG_W = DEFAULT_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG_W);

  if (SEG_W == 0 || WIDTH == 0 || (WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  // src[k] is what stage k sees before resolving its own segment; its carry is the carry-in.
  stage_t           stg   [NSEG];
  stage_t           src   [NSEG];
  stage_t           nxt   [NSEG];
  logic [SEG_W-1:0] seg_s [NSEG];
  logic [NSEG-1:0]  seg_co;
  logic             stall;

  assign stall    = stg[NSEG-1].ctl.valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    if (k == 0) begin : g_first
      assign src[0] = '{ctl: '{valid: in_valid, carry: in_sub},
                        a:   in_a,
                        b:   (in_sub ? ~in_b : in_b),
                        sum: '0};
    end else begin : g_rest
      assign src[k] = stg[k-1];
    end

    adder_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (src[k].a[k*SEG_W +: SEG_W]),
      .b    (src[k].b[k*SEG_W +: SEG_W]),
      .cin  (src[k].ctl.carry),
      .s    (seg_s[k]),
      .cout (seg_co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      nxt[k]                          = src[k];
      nxt[k].sum[k*SEG_W +: SEG_W]    = seg_s[k];
      nxt[k].ctl.carry                = seg_co[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) stg[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < NSEG; k++) stg[k] <= nxt[k];
    end
  end

  assign out_valid = stg[NSEG-1].ctl.valid;
  assign out_sum   = stg[NSEG-1].sum;
  assign out_carry = stg[NSEG-1].ctl.carry;

`ifdef PIPE_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic cin_msb;
  assign cin_msb = seg_s[NSEG-1][SEG_W-1] ^ src[NSEG-1].a[WIDTH-1] ^ src[NSEG-1].b[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_ovf <= 1'b0;
    else if (!stall) out_ovf <= cin_msb ^ seg_co[NSEG-1];
  end
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed cases, random streams and a FIFO reference model.
module tb_pipe_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_carry;

  logic         v16 = 1'b0;
  logic         r16;
  logic [15:0]  a16 = '0;
  logic [15:0]  b16 = '0;
  logic         ov16;
  logic [15:0]  s16;
  logic         c16;
`ifdef PIPE_ADDER_OVF_EN
  logic         out_ovf;
  logic         ovf16;
`endif

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipe_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef PIPE_ADDER_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_carry (out_carry)
  );

  pipe_adder #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .in_ready  (r16),
    .in_a      (a16),
    .in_b      (b16),
    .in_sub    (1'b0),
    .out_valid (ov16),
    .out_ready (1'b1),
    .out_sum   (s16),
`ifdef PIPE_ADDER_OVF_EN
    .out_ovf   (ovf16),
`endif
    .out_carry (c16)
  );

  // Reference: plain unsigned arithmetic plus the textbook signed-overflow rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t       e;
    logic [W:0] wide;
    if (!sub) begin
      wide    = {1'b0, a} + {1'b0, b};
      e.sum   = wide[W-1:0];
      e.carry = wide[W];
      e.ovf   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    end else begin
      e.sum   = a - b;
      e.carry = (a >= b);
      e.ovf   = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    return e;
  endfunction

  // Scoreboard: record accepted inputs, compare emitted results in order, check holds under stall.
  initial begin : monitor
    logic         prev_stall;
    logic [W-1:0] prev_sum;
    logic         prev_carry;
    exp_t         e;
    prev_stall = 1'b0;
    prev_sum   = '0;
    prev_carry = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== prev_sum || out_carry !== prev_carry) begin
          errors++;
          $display("FAIL hold: valid=%b sum=%h carry=%b, required valid=1 sum=%h carry=%b",
                   out_valid, out_sum, out_carry, prev_sum, prev_carry);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: sum=%h carry=%b, required no output", out_sum, out_carry);
        end else begin
          e = q.pop_front();
          if (out_sum !== e.sum || out_carry !== e.carry) begin
            errors++;
            $display("FAIL result: sum=%h carry=%b, required sum=%h carry=%b",
                     out_sum, out_carry, e.sum, e.carry);
          end
`ifdef PIPE_ADDER_OVF_EN
          vectors++;
          if (out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf_model: ovf=%b, required %b", out_ovf, e.ovf);
          end
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub));
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_carry = out_carry;
    end
  end

  // Drives one operation and returns one step after the edge that accepted it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b sum=%h carry=%b in_ready=%b, required 0 0 0 1",
               out_valid, out_sum, out_carry, in_ready);
    end
`ifdef PIPE_ADDER_OVF_EN
    vectors++;
    if (out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b, required 0", out_ovf);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple();
    int lat;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat + 1 !== 4) begin
      errors++;
      $display("FAIL ripple_latency: %0d register stages, required 4", lat + 1);
    end
    vectors++;
    if (out_sum !== 32'h0 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL ripple_result: sum=%h carry=%b, required 00000000 1", out_sum, out_carry);
    end
    wait_drain();
  endtask

  task automatic test_borrow();
    int n;
    send(32'd5, 32'd7, 1'b1);
    send(32'd7, 32'd5, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 32'hFFFF_FFFE || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL borrow_5_7: valid=%b sum=%h carry=%b, required 1 fffffffe 0", out_valid, out_sum, out_carry);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0000_0002 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL borrow_7_5: valid=%b sum=%h carry=%b, required 1 00000002 1", out_valid, out_sum, out_carry);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom();
      in_b     = $urandom();
      in_sub   = 1'($urandom_range(0, 1));
      if (i == 5) begin
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          #1;
          vectors++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: cycle %0d in_ready=%b, required 0", c, in_ready);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_high: op %0d in_ready=%b, required 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = $urandom();
      in_b      = (i % 7 == 0) ? in_a : $urandom();
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b1;
    send(32'h1111_1111, 32'h2222_2222, 1'b0);
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    out_ready = 1'b0;
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 32'h3333_3333) begin
      errors++;
      $display("FAIL pre_reset: valid=%b sum=%h, required 1 33333333", out_valid, out_sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b sum=%h carry=%b, required 0 0 0", out_valid, out_sum, out_carry);
    end
    q.delete();
    out_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL discarded_emitted: %0d outputs after reset, required 0", seen);
    end
  endtask

`ifdef PIPE_ADDER_OVF_EN
  task automatic test_overflow();
    int n;
    out_ready = 1'b1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    send(32'h0000_0003, 32'h0000_0004, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (out_ovf !== 1'b1 || out_sum !== 32'h8000_0000) begin
      errors++;
      $display("FAIL ovf_add: ovf=%b sum=%h, required 1 80000000", out_ovf, out_sum);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_ovf !== 1'b1 || out_sum !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL ovf_sub: ovf=%b sum=%h, required 1 7fffffff", out_ovf, out_sum);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_ovf !== 1'b0 || out_sum !== 32'h0000_0007) begin
      errors++;
      $display("FAIL ovf_none: ovf=%b sum=%h, required 0 00000007", out_ovf, out_sum);
    end
    wait_drain();
  endtask
`endif

  task automatic test_reparam();
    int lat;
    v16 = 1'b1;
    a16 = 16'hABCD;
    b16 = 16'h1234;
    #1;
    vectors++;
    if (r16 !== 1'b1) begin
      errors++;
      $display("FAIL w16_ready: in_ready=%b, required 1", r16);
    end
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat + 1 !== 4) begin
      errors++;
      $display("FAIL w16_latency: %0d register stages, required 4", lat + 1);
    end
    vectors++;
    if (s16 !== 16'hBE01 || c16 !== 1'b0) begin
      errors++;
      $display("FAIL w16_result: sum=%h carry=%b, required be01 0", s16, c16);
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_borrow();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
`ifdef PIPE_ADDER_OVF_EN
    test_overflow();
`endif
    test_reparam();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
